// File: rtl/rotor_stepper.sv
// Enigma rotor stepping controller: advances left/middle/right positions per
// keypress with notch carry, middle-rotor double-step and two-notch rotors.
//
// state | meaning
// IDLE  | ready for a keypress; rotor types latched on accept
// CALC  | advance flags registered from latched types and current positions
// APPLY | new positions written, key_count bumped, pos_valid queued
module rotor_stepper #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [4:0]       load_pos_l,
   input  logic [4:0]       load_pos_m,
   input  logic [4:0]       load_pos_r,
   input  logic [2:0]       type_l,
   input  logic [2:0]       type_m,
   input  logic [2:0]       type_r,
   input  logic             step_valid,
   output logic             step_ready,
   output logic [4:0]       pos_l,
   output logic [4:0]       pos_m,
   output logic [4:0]       pos_r,
   output logic             pos_valid,
   output logic [CNT_W-1:0] key_count
);

   typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;

   state_t     state, state_nxt;
   logic [2:0] typ_m_q, typ_r_q;
   logic       adv_m_q, adv_l_q;
   logic       accept;
   logic       unused_type_l;

   // The left rotor has no carry out, so its type never affects stepping.
   assign unused_type_l = ^type_l;

   function automatic logic notch_hit(input logic [2:0] t, input logic [4:0] p);
      logic hit;
      case (t)
         3'd0:    hit = (p == 5'd16);
         3'd1:    hit = (p == 5'd4);
         3'd2:    hit = (p == 5'd21);
         3'd3:    hit = (p == 5'd9);
         3'd4:    hit = (p == 5'd25);
         default: hit = (p == 5'd25) || (p == 5'd12);
      endcase
      return hit;
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p == 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   function automatic logic [4:0] mod26(input logic [4:0] p);
      return (p >= 5'd26) ? p - 5'd26 : p;
   endfunction

   assign step_ready = (state == IDLE);
   assign accept     = step_ready && step_valid && !load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (step_valid) state_nxt = CALC;
            CALC:    state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_l     <= 5'd0;
         pos_m     <= 5'd0;
         pos_r     <= 5'd0;
         pos_valid <= 1'b0;
         key_count <= '0;
         typ_m_q   <= 3'd0;
         typ_r_q   <= 3'd0;
         adv_m_q   <= 1'b0;
         adv_l_q   <= 1'b0;
      end else begin
         pos_valid <= 1'b0;
         if (load) begin
            pos_l     <= mod26(load_pos_l);
            pos_m     <= mod26(load_pos_m);
            pos_r     <= mod26(load_pos_r);
            key_count <= '0;
         end else begin
            if (accept) begin
               typ_m_q <= type_m;
               typ_r_q <= type_r;
            end
            if (state == CALC) begin
               adv_m_q <= notch_hit(typ_r_q, pos_r) || notch_hit(typ_m_q, pos_m);
               adv_l_q <= notch_hit(typ_m_q, pos_m);
            end
            if (state == APPLY) begin
               pos_r     <= inc26(pos_r);
               if (adv_m_q) pos_m <= inc26(pos_m);
               if (adv_l_q) pos_l <= inc26(pos_l);
               key_count <= key_count + CNT_W'(1);
               pos_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed testbench for rotor_stepper: reset, carry, double-step, two-notch
// rotors, type sampling, load priority, async reset and back-to-back steps.
module tb_rotor_stepper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [4:0]  load_pos_l = 5'd0, load_pos_m = 5'd0, load_pos_r = 5'd0;
   logic [2:0]  type_l = 3'd0, type_m = 3'd1, type_r = 3'd2;
   logic        step_valid = 1'b0;
   logic        step_ready;
   logic [4:0]  pos_l, pos_m, pos_r;
   logic        pos_valid;
   logic [15:0] key_count;

   int tests_run = 0;
   int tests_failed = 0;

   rotor_stepper #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .load(load),
      .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
      .type_l(type_l), .type_m(type_m), .type_r(type_r),
      .step_valid(step_valid), .step_ready(step_ready),
      .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
      .pos_valid(pos_valid), .key_count(key_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
      load = 1'b1; load_pos_l = l; load_pos_m = m; load_pos_r = r;
      tick();
      load = 1'b0;
   endtask

   // Leaves the bench just after edge N+2, where pos_valid should be high.
   task automatic run_step();
      step_valid = 1'b1;
      tick();
      step_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_pos: got %0d,%0d,%0d want 0,0,0", pos_l, pos_m, pos_r);
      end
      tests_run++;
      if ({step_ready, pos_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_flags: ready=%b valid=%b want ready=1 valid=0", step_ready, pos_valid);
      end
      tests_run++;
      if (key_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_count: got %0d want 0", key_count);
      end
   endtask

   task automatic test_carry();
      type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
      do_load(5'd0, 5'd0, 5'd21);
      step_valid = 1'b1;
      tick();                               // edge N
      step_valid = 1'b0;
      tests_run++;
      if (step_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL carry_ready_n: got %b want 0", step_ready);
      end
      tick();                               // edge N+1
      tests_run++;
      if ({pos_valid, step_ready, pos_l, pos_m, pos_r} !== {1'b0, 1'b0, 5'd0, 5'd0, 5'd21}) begin
         tests_failed++;
         $display("FAIL carry_n1: valid=%b ready=%b pos=%0d,%0d,%0d want 0 0 0,0,21",
                  pos_valid, step_ready, pos_l, pos_m, pos_r);
      end
      tick();                               // edge N+2
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd22}) begin
         tests_failed++;
         $display("FAIL carry_pos: got %0d,%0d,%0d want 0,1,22", pos_l, pos_m, pos_r);
      end
      tests_run++;
      if ({pos_valid, step_ready} !== 2'b11 || key_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL carry_n2: valid=%b ready=%b count=%0d want 1 1 1", pos_valid, step_ready, key_count);
      end
      tick();                               // edge N+3
      tests_run++;
      if (pos_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL carry_pulse_len: valid=%b want 0", pos_valid);
      end
   endtask

   task automatic test_double_step();
      logic [14:0] exp_tab [3];
      exp_tab[0] = {5'd0, 5'd3, 5'd21};
      exp_tab[1] = {5'd0, 5'd4, 5'd22};
      exp_tab[2] = {5'd1, 5'd5, 5'd23};
      type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
      do_load(5'd0, 5'd3, 5'd20);
      for (int i = 0; i < 3; i++) begin
         run_step();
         tests_run++;
         if ({pos_l, pos_m, pos_r} !== exp_tab[i] || pos_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL double_step_%0d: got %0d,%0d,%0d valid=%b want %0d,%0d,%0d valid=1", i,
                     pos_l, pos_m, pos_r, pos_valid, exp_tab[i][14:10], exp_tab[i][9:5], exp_tab[i][4:0]);
         end
         tick();
      end
      tests_run++;
      if (key_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL double_step_count: got %0d want 3", key_count);
      end
   endtask

   task automatic test_two_notch();
      logic [4:0]  start_r [3];
      logic [14:0] exp_tab [3];
      start_r[0] = 5'd25; exp_tab[0] = {5'd0, 5'd1, 5'd0};
      start_r[1] = 5'd12; exp_tab[1] = {5'd0, 5'd1, 5'd13};
      start_r[2] = 5'd13; exp_tab[2] = {5'd0, 5'd0, 5'd14};
      type_l = 3'd0; type_m = 3'd0; type_r = 3'd5;
      for (int i = 0; i < 3; i++) begin
         do_load(5'd0, 5'd0, start_r[i]);
         run_step();
         tests_run++;
         if ({pos_l, pos_m, pos_r} !== exp_tab[i]) begin
            tests_failed++;
            $display("FAIL two_notch_%0d: got %0d,%0d,%0d want %0d,%0d,%0d", i,
                     pos_l, pos_m, pos_r, exp_tab[i][14:10], exp_tab[i][9:5], exp_tab[i][4:0]);
         end
         tick();
      end
      // Rotor VIII second notch on the middle rotor drives left and double-step.
      type_m = 3'd7; type_r = 3'd0;
      do_load(5'd2, 5'd12, 5'd3);
      run_step();
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd3, 5'd13, 5'd4}) begin
         tests_failed++;
         $display("FAIL two_notch_mid: got %0d,%0d,%0d want 3,13,4", pos_l, pos_m, pos_r);
      end
      tick();
   endtask

   task automatic test_type_sampling();
      type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
      do_load(5'd0, 5'd0, 5'd21);
      step_valid = 1'b1;
      tick();
      step_valid = 1'b0;
      type_r = 3'd0;                        // notch would no longer match at 21
      type_m = 3'd4;
      tick();
      tick();
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd22}) begin
         tests_failed++;
         $display("FAIL type_sampling: got %0d,%0d,%0d want 0,1,22", pos_l, pos_m, pos_r);
      end
      tick();
      type_m = 3'd1; type_r = 3'd2;
   endtask

   task automatic test_load_mid_step();
      type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
      do_load(5'd0, 5'd0, 5'd0);
      step_valid = 1'b1;
      tick();                               // accepted, now CALC
      step_valid = 1'b0;
      do_load(5'd7, 5'd8, 5'd30);
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd7, 5'd8, 5'd4}) begin
         tests_failed++;
         $display("FAIL load_mid_pos: got %0d,%0d,%0d want 7,8,4", pos_l, pos_m, pos_r);
      end
      tests_run++;
      if ({step_ready, pos_valid} !== 2'b10 || key_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL load_mid_flags: ready=%b valid=%b count=%0d want 1 0 0", step_ready, pos_valid, key_count);
      end
      tick();
      tick();
      tests_run++;
      if ({pos_valid, pos_l, pos_m, pos_r} !== {1'b0, 5'd7, 5'd8, 5'd4} || key_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL load_mid_discard: valid=%b pos=%0d,%0d,%0d count=%0d want 0 7,8,4 0",
                  pos_valid, pos_l, pos_m, pos_r, key_count);
      end
      // Load and step_valid together: load wins, no step follows.
      step_valid = 1'b1;
      do_load(5'd31, 5'd26, 5'd1);
      step_valid = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd5, 5'd0, 5'd1} || key_count !== 16'd0 || pos_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_priority: pos=%0d,%0d,%0d count=%0d valid=%b want 5,0,1 0 0",
                  pos_l, pos_m, pos_r, key_count, pos_valid);
      end
   endtask

   task automatic test_reset_mid_step();
      do_load(5'd3, 5'd4, 5'd5);
      run_step();                           // pos_valid high, count 1
      step_valid = 1'b1;
      tick();
      step_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== 15'd0 || key_count !== 16'd0 || {step_ready, pos_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_async: pos=%0d,%0d,%0d count=%0d ready=%b valid=%b want 0,0,0 0 1 0",
                  pos_l, pos_m, pos_r, key_count, step_ready, pos_valid);
      end
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      int acc [$];
      type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
      do_load(5'd0, 5'd0, 5'd0);
      step_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (step_ready) acc.push_back(i);
         tick();
      end
      step_valid = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (acc.size() != 10) begin
         tests_failed++;
         $display("FAIL b2b_accepts: got %0d want 10", acc.size());
      end
      for (int i = 1; i < acc.size(); i++) begin
         tests_run++;
         if (acc[i] - acc[i-1] != 3) begin
            tests_failed++;
            $display("FAIL b2b_gap_%0d: got %0d want 3", i, acc[i] - acc[i-1]);
         end
      end
      tests_run++;
      if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd10} || key_count !== 16'd10) begin
         tests_failed++;
         $display("FAIL b2b_final: pos=%0d,%0d,%0d count=%0d want 0,0,10 10",
                  pos_l, pos_m, pos_r, key_count);
      end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_double_step();
      test_two_notch();
      test_type_sampling();
      test_load_mid_step();
      test_reset_mid_step();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
